// File: rtl/lut_prod_acc_if.sv
// Product-in / sum-out handshake bundle for lut_prod_accumulator.
// LUT_ACC_SATURATE_EN adds the out_ovf flag to the result side.
interface lut_prod_acc_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 19
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_count;
`ifdef LUT_ACC_SATURATE_EN
  logic              out_ovf;

  modport master (output in_valid, in_prod, in_last, out_ready,
                  input  in_ready, out_valid, out_sum, out_count, out_ovf);
  modport slave  (input  in_valid, in_prod, in_last, out_ready,
                  output in_ready, out_valid, out_sum, out_count, out_ovf);
`else
  modport master (output in_valid, in_prod, in_last, out_ready,
                  input  in_ready, out_valid, out_sum, out_count);
  modport slave  (input  in_valid, in_prod, in_last, out_ready,
                  output in_ready, out_valid, out_sum, out_count);
`endif
endinterface

// File: rtl/lut_prod_accumulator.sv
// Frame accumulator for the LUT constant-multiplier product stream.
// Optional LUT_ACC_SATURATE_EN: saturating add plus out_ovf flag; default wraps modulo 2^ACC_W.
module lut_prod_accumulator #(
  parameter int unsigned PROD_W  = 16,
  parameter int unsigned ACC_LEN = 8,
  parameter int unsigned ACC_W   = 19
) (
  input  logic           clk,
  input  logic           rst,
  lut_prod_acc_if.slave  bus,
  output logic           busy
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_add;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              in_ready;
  logic              out_valid;
  logic              beat;
  logic              done;
`ifdef LUT_ACC_SATURATE_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  logic [SUM_W-1:0]  sum_wide;
  logic              add_ovf;
  logic              frame_ovf;
  logic              out_ovf;
`endif

  // Beat qualification, next accumulator value and frame-completion detect
  always_comb begin
    beat    = bus.in_valid && in_ready;
    cnt_inc = cnt + CNT_W'(1);
    done    = beat && (bus.in_last || (cnt_inc == CNT_W'(ACC_LEN)));
`ifdef LUT_ACC_SATURATE_EN
    sum_wide = SUM_W'(acc) + SUM_W'(bus.in_prod);
    add_ovf  = sum_wide[ACC_W];
    acc_add  = add_ovf ? '1 : sum_wide[ACC_W-1:0];
`else
    acc_add  = acc + ACC_W'(bus.in_prod);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      busy      <= 1'b0;
`ifdef LUT_ACC_SATURATE_EN
      frame_ovf <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat) begin
            acc  <= acc_add;
            cnt  <= cnt_inc;
            busy <= 1'b1;
`ifdef LUT_ACC_SATURATE_EN
            frame_ovf <= frame_ovf | add_ovf;
`endif
            if (done) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= acc_add;
              out_count <= cnt_inc;
`ifdef LUT_ACC_SATURATE_EN
              out_ovf   <= frame_ovf | add_ovf;
`endif
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it; accumulator clears with the handshake
          if (bus.out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef LUT_ACC_SATURATE_EN
            frame_ovf <= 1'b0;
            out_ovf   <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
`ifdef LUT_ACC_SATURATE_EN
  assign bus.out_ovf   = out_ovf;
`endif

endmodule
